// File: rtl/bin_to_7seg_driver.sv
// bin_to_7seg_driver: sequential 16-bit binary to five-digit BCD converter
// using an iterative double-dabble engine. It drives five registered
// seven-segment displays with optional leading-zero blanking.
module bin_to_7seg_driver #(
   parameter int BLANK_LEADING  = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value_in,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [19:0] bcd_out,
   output logic [6:0]  display1,
   output logic [6:0]  display2,
   output logic [6:0]  display3,
   output logic [6:0]  display4,
   output logic [6:0]  display5
);

   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

   localparam logic [6:0] SEG_BLANK_AL = 7'b1111111;
   localparam logic [6:0] SEG_BLANK    = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK_AL : ~SEG_BLANK_AL;

   state_t      state;
   logic [15:0] bin_reg;
   logic [19:0] scratch;
   logic [4:0]  cnt;

   logic [19:0] adj;
   logic [35:0] shift_next;
   logic [4:0]  zero_above;
   logic [6:0]  seg_next [5];

   // Segment pattern for one digit, in the board's polarity.
   function automatic logic [6:0] seg_pattern(input logic [3:0] d, input logic blank);
      logic [6:0] p;
      if (blank) begin
         p = SEG_BLANK_AL;
      end else begin
         case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK_AL;
         endcase
      end
      return (SEG_ACTIVE_LOW != 0) ? p : ~p;
   endfunction

   // Double-dabble step: add 3 to every nibble >= 5, then shift {scratch, binary} left.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      adj = scratch;
      for (int i = 0; i < 5; i++) begin
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      shift_next = {adj, bin_reg} << 1;
   end

   // Segment values loaded at UPDATE; a digit blanks when it and all higher digits are zero.
   always_comb begin
      zero_above[4] = (scratch[19:16] == 4'd0);
      for (int k = 3; k >= 0; k--) begin
         zero_above[k] = (scratch[4*k +: 4] == 4'd0) && zero_above[k+1];
      end
      for (int k = 0; k < 5; k++) begin
         seg_next[k] = seg_pattern(scratch[4*k +: 4],
                                   (BLANK_LEADING != 0) && (k != 0) && zero_above[k]);
      end
   end

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd_out  <= '0;
         bin_reg  <= '0;
         scratch  <= '0;
         cnt      <= '0;
         display1 <= SEG_BLANK;
         display2 <= SEG_BLANK;
         display3 <= SEG_BLANK;
         display4 <= SEG_BLANK;
         display5 <= SEG_BLANK;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  bin_reg <= value_in;
                  scratch <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= shift_next[35:16];
               bin_reg <= shift_next[15:0];
               cnt     <= cnt + 5'd1;
               if (cnt == 5'd15) state <= UPDATE;
            end
            UPDATE: begin
               bcd_out  <= scratch;
               display1 <= seg_next[0];
               display2 <= seg_next[1];
               display3 <= seg_next[2];
               display4 <= seg_next[3];
               display5 <= seg_next[4];
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
